// File: rtl/timer_pwm_pkg.sv
// Shared types and constants for the multi-channel PWM timer.
// Build option: define TIMER_PWM_CAPTURE_EN to add per-channel input capture
// (see timer_pwm_chan and timer_pwm_mc).
package timer_pwm_pkg;

  // Default widths for the timer core
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_PSC_W = 32;

  // Per-channel alignment mode, as seen on i_center
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Counting direction of a channel
  typedef enum logic [0:0] {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } cnt_state_t;

endpackage

// File: rtl/timer_pwm_chan.sv
// One PWM channel: counter, UP/DOWN state, shadow period/compare/mode, registered
// PWM output and period event. Optional input capture when TIMER_PWM_CAPTURE_EN
// is defined.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tick          shared prescaler tick (1 clk wide)
//   enable        channel run enable
//   center        requested mode (1 = centre-aligned), shadowed
//   pol           output polarity, 1 inverts the PWM
//   period        requested period, shadowed
//   compare       requested duty compare, shadowed
//   counter       live counter
//   dir           1 while counting down
//   period_evt    1-clk pulse coincident with the counter wrap
//   pwm           registered PWM output
//   capture       (TIMER_PWM_CAPTURE_EN) asynchronous capture input
//   capture_val   (TIMER_PWM_CAPTURE_EN) counter value captured on a rising edge
//   capture_vld   (TIMER_PWM_CAPTURE_EN) 1-clk pulse when capture_val is updated
module timer_pwm_chan
  import timer_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             center,
  input  logic             pol,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] compare,
`ifdef TIMER_PWM_CAPTURE_EN
  input  logic             capture,
  output logic [CNT_W-1:0] capture_val,
  output logic             capture_vld,
`endif
  output logic [CNT_W-1:0] counter,
  output logic             dir,
  output logic             period_evt,
  output logic             pwm
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cnt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_act_q, per_act_d;
  logic [CNT_W-1:0] cmp_act_q, cmp_act_d;
  logic             mode_act_q, mode_act_d;
  logic             evt_q, evt_d;
  logic             pwm_q, pwm_d;
  logic             wrap;
  logic             commit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UP;
      cnt_q      <= '0;
      per_act_q  <= '0;
      cmp_act_q  <= '0;
      mode_act_q <= MODE_EDGE;
      evt_q      <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_act_q  <= per_act_d;
      cmp_act_q  <= cmp_act_d;
      mode_act_q <= mode_act_d;
      evt_q      <= evt_d;
      pwm_q      <= pwm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = ST_UP;
      cnt_d   = '0;
    end else if (tick) begin
      if (per_act_q == '0) begin
        wrap = 1'b1;
      end else if (mode_act_q == MODE_CENTER) begin
        unique case (state_q)
          ST_UP: begin
            if (cnt_q == per_act_q) begin
              // Period of 1 would turn around at 0 and underflow; wrap straight
              // from the top instead, which keeps the 2*period tick length.
              if (per_act_q == ONE) begin
                wrap = 1'b1;
              end else begin
                state_d = ST_DOWN;
                cnt_d   = cnt_q - ONE;
              end
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          ST_DOWN: begin
            if (cnt_q == ONE) begin
              wrap = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        endcase
      end else begin
        if (cnt_q == per_act_q) begin
          wrap = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      if (wrap) begin
        // Every period, and every newly committed mode, starts UP from 0
        state_d = ST_UP;
        cnt_d   = '0;
      end
    end
  end

  // Shadows follow the inputs while disabled and load only at a wrap otherwise,
  // so the counter can never sit above the active period.
  assign commit     = !enable || wrap;
  assign per_act_d  = commit ? period  : per_act_q;
  assign cmp_act_d  = commit ? compare : cmp_act_q;
  assign mode_act_d = commit ? center  : mode_act_q;

  // Output logic
  always_comb begin
    evt_d = wrap;
    pwm_d = pol;
    if (enable) begin
      pwm_d = (cnt_q < cmp_act_q) ^ pol;
    end
    counter    = cnt_q;
    dir        = (state_q == ST_DOWN);
    period_evt = evt_q;
    pwm        = pwm_q;
  end

`ifdef TIMER_PWM_CAPTURE_EN
  logic [2:0]       cap_sync_q;
  logic             cap_edge;
  logic             cap_vld_q;
  logic [CNT_W-1:0] cap_val_q;

  // Bits [1:0] synchronise, bit [2] is the previous synchronised sample
  assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_sync_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_val_q  <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], capture};
      cap_vld_q  <= enable & cap_edge;
      // Store the counter value being loaded on this edge, so capture_val matches
      // counter while capture_vld is high.
      if (enable && cap_edge) begin
        cap_val_q <= cnt_d;
      end
    end
  end

  assign capture_val = cap_val_q;
  assign capture_vld = cap_vld_q;
`endif

endmodule

// File: rtl/timer_pwm_mc.sv
// N-channel PWM timer core: a shared prescaler plus NCH independent channels,
// each edge- or centre-aligned with glitch-free shadowed period/compare updates.
// Build option: TIMER_PWM_CAPTURE_EN adds per-channel input capture ports.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_enable        per-channel run enable
//   i_center        per-channel mode, 1 = centre-aligned (shadowed)
//   i_pol           per-channel output polarity, 1 inverts
//   i_prescaler     tick every (i_prescaler+1) clk
//   i_period        per-channel period, channel k at [k*CNT_W +: CNT_W] (shadowed)
//   i_compare       per-channel duty compare, same packing (shadowed)
//   o_counter       live counters, same packing
//   o_dir           1 = counting down
//   o_period_evt    1-clk pulse at each period boundary
//   o_pwm           registered PWM outputs
//   i_capture       (TIMER_PWM_CAPTURE_EN) capture inputs
//   o_capture_val   (TIMER_PWM_CAPTURE_EN) captured counter values
//   o_capture_vld   (TIMER_PWM_CAPTURE_EN) capture valid pulses
module timer_pwm_mc
  import timer_pwm_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PSC_W = DEF_PSC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       i_enable,
  input  logic [NCH-1:0]       i_center,
  input  logic [NCH-1:0]       i_pol,
  input  logic [PSC_W-1:0]     i_prescaler,
  input  logic [NCH*CNT_W-1:0] i_period,
  input  logic [NCH*CNT_W-1:0] i_compare,
`ifdef TIMER_PWM_CAPTURE_EN
  input  logic [NCH-1:0]       i_capture,
  output logic [NCH*CNT_W-1:0] o_capture_val,
  output logic [NCH-1:0]       o_capture_vld,
`endif
  output logic [NCH*CNT_W-1:0] o_counter,
  output logic [NCH-1:0]       o_dir,
  output logic [NCH-1:0]       o_period_evt,
  output logic [NCH-1:0]       o_pwm
);

  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic             any_en;
  logic             tick;

  assign any_en = |i_enable;
  // >= rather than == so a prescaler value lowered below the running count
  // terminates the current tick interval instead of running through overflow.
  assign tick   = any_en && (psc_cnt_q >= i_prescaler);

  always_comb begin
    psc_cnt_d = psc_cnt_q + PSC_W'(1);
    if (!any_en || tick) begin
      psc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    timer_pwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .enable      (i_enable[k]),
      .center      (i_center[k]),
      .pol         (i_pol[k]),
      .period      (i_period[k*CNT_W +: CNT_W]),
      .compare     (i_compare[k*CNT_W +: CNT_W]),
`ifdef TIMER_PWM_CAPTURE_EN
      .capture     (i_capture[k]),
      .capture_val (o_capture_val[k*CNT_W +: CNT_W]),
      .capture_vld (o_capture_vld[k]),
`endif
      .counter     (o_counter[k*CNT_W +: CNT_W]),
      .dir         (o_dir[k]),
      .period_evt  (o_period_evt[k]),
      .pwm         (o_pwm[k])
    );
  end

endmodule

// File: tb/tb_timer_pwm_mc.sv
// Directed bench for timer_pwm_mc: two 8-bit channels, channel 0 exercised,
// channel 1 left disabled with inverted polarity.
module tb_timer_pwm_mc;
  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PSC_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       enable, center, pol;
  logic [PSC_W-1:0]     prescaler;
  logic [NCH*CNT_W-1:0] period, compare, counter;
  logic [NCH-1:0]       dir, period_evt, pwm;
`ifdef TIMER_PWM_CAPTURE_EN
  logic [NCH-1:0]       capture, capture_vld;
  logic [NCH*CNT_W-1:0] capture_val;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Expected sequences, one entry per clk after enabling
  int t1_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int t1_pwm [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  int t1_evt [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int t2_cnt [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
  int t2_dir [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
  int t2_pwm [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  int t2_evt [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int t3_cnt [12] = '{3, 4, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int t3_pwm [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1};
  int t3_evt [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t4_cnt [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int t4_pwm [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
  int t4_evt [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  timer_pwm_mc #(
    .NCH  (NCH),
    .CNT_W(CNT_W),
    .PSC_W(PSC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (enable),
    .i_center     (center),
    .i_pol        (pol),
    .i_prescaler  (prescaler),
    .i_period     (period),
    .i_compare    (compare),
`ifdef TIMER_PWM_CAPTURE_EN
    .i_capture    (capture),
    .o_capture_val(capture_val),
    .o_capture_vld(capture_vld),
`endif
    .o_counter    (counter),
    .o_dir        (dir),
    .o_period_evt (period_evt),
    .o_pwm        (pwm)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Disable channel 0, load its configuration while disabled, then enable it
  task automatic cfg(input int per, input int cmp, input logic ctr, input logic pl);
    enable[0] = 1'b0;
    step();
    period[7:0]  = 8'(per);
    compare[7:0] = 8'(cmp);
    center[0]    = ctr;
    pol[0]       = pl;
    step();
    enable[0] = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = '0;
    center    = '0;
    pol       = 2'b10;
    prescaler = '0;
    period    = '0;
    compare   = '0;
`ifdef TIMER_PWM_CAPTURE_EN
    capture   = '0;
`endif
    step(2);
    // Reset state, pol[1]=1 must not leak through while in reset
    chk("rst_counter", 32'(counter), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_evt", 32'(period_evt), 0);
    chk("rst_pwm", 32'(pwm), 0);
    rst = 1'b0;

    // T1 edge mode
    cfg(4, 2, 1'b0, 1'b0);
    chk("t1_dis_cnt", 32'(counter[7:0]), 0);
    chk("t1_dis_pwm", 32'(pwm[0]), 0);
    chk("ch1_pwm_pol", 32'(pwm[1]), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t1_cnt[%0d]", i), 32'(counter[7:0]), 32'(t1_cnt[i]));
      chk($sformatf("t1_pwm[%0d]", i), 32'(pwm[0]), 32'(t1_pwm[i]));
      chk($sformatf("t1_evt[%0d]", i), 32'(period_evt[0]), 32'(t1_evt[i]));
    end
    chk("ch1_cnt", 32'(counter[15:8]), 0);

    // T2 centre mode
    cfg(3, 2, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t2_cnt[%0d]", i), 32'(counter[7:0]), 32'(t2_cnt[i]));
      chk($sformatf("t2_dir[%0d]", i), 32'(dir[0]), 32'(t2_dir[i]));
      chk($sformatf("t2_pwm[%0d]", i), 32'(pwm[0]), 32'(t2_pwm[i]));
      chk($sformatf("t2_evt[%0d]", i), 32'(period_evt[0]), 32'(t2_evt[i]));
    end

    // T3 shadow update mid-period
    cfg(4, 2, 1'b0, 1'b0);
    step(2);
    chk("t3_pre_cnt", 32'(counter[7:0]), 2);
    period[7:0]  = 8'd7;
    compare[7:0] = 8'd5;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t3_cnt[%0d]", i), 32'(counter[7:0]), 32'(t3_cnt[i]));
      chk($sformatf("t3_pwm[%0d]", i), 32'(pwm[0]), 32'(t3_pwm[i]));
      chk($sformatf("t3_evt[%0d]", i), 32'(period_evt[0]), 32'(t3_evt[i]));
    end

    // T4 prescaler, then disable mid-count
    prescaler = 8'd2;
    cfg(1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t4_cnt[%0d]", i), 32'(counter[7:0]), 32'(t4_cnt[i]));
      chk($sformatf("t4_pwm[%0d]", i), 32'(pwm[0]), 32'(t4_pwm[i]));
      chk($sformatf("t4_evt[%0d]", i), 32'(period_evt[0]), 32'(t4_evt[i]));
    end
    step(3);
    chk("t4_mid_cnt", 32'(counter[7:0]), 1);
    enable[0] = 1'b0;
    pol[0]    = 1'b1;
    step();
    chk("t4_dis_cnt", 32'(counter[7:0]), 0);
    chk("t4_dis_pwm", 32'(pwm[0]), 1);
    chk("t4_dis_evt", 32'(period_evt[0]), 0);
    chk("t4_dis_dir", 32'(dir[0]), 0);
    prescaler = 8'd0;

    // T5 compare boundaries and polarity
    cfg(3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t5_cmp0[%0d]", i), 32'(pwm[0]), 0);
    end
    cfg(3, 4, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t5_cmpmax[%0d]", i), 32'(pwm[0]), 1);
    end
    cfg(3, 4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_cmpmax_inv[%0d]", i), 32'(pwm[0]), 0);
    end
    cfg(3, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_cmp0_inv[%0d]", i), 32'(pwm[0]), 1);
    end
    // Period 0: event every tick in both modes
    cfg(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_per0_evt[%0d]", i), 32'(period_evt[0]), 1);
      chk($sformatf("t5_per0_cnt[%0d]", i), 32'(counter[7:0]), 0);
    end
    cfg(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_per0c_evt[%0d]", i), 32'(period_evt[0]), 1);
    end

`ifdef TIMER_PWM_CAPTURE_EN
    // T6 input capture
    cfg(9, 3, 1'b0, 1'b0);
    step(5);
    chk("t6_cnt5", 32'(counter[7:0]), 5);
    capture[0] = 1'b1;
    step(2);
    chk("t6_vld_early", 32'(capture_vld[0]), 0);
    step();
    chk("t6_vld", 32'(capture_vld[0]), 1);
    chk("t6_val", 32'(capture_val[7:0]), 8);
    step();
    chk("t6_vld_end", 32'(capture_vld[0]), 0);
    capture[0] = 1'b0;
`endif

    // Asynchronous reset mid-run
    cfg(4, 2, 1'b0, 1'b0);
    step(2);
    chk("t5_run_cnt", 32'(counter[7:0]), 2);
    chk("t5_run_pwm", 32'(pwm[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_arst_cnt", 32'(counter), 0);
    chk("t5_arst_pwm", 32'(pwm), 0);
    chk("t5_arst_evt", 32'(period_evt), 0);
    chk("t5_arst_dir", 32'(dir), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
